// File: rtl/dsp_mac_slice.sv
// Pipelined pre-add / multiply / accumulate slice with valid tracking, clock enable,
// optional saturation and a sticky overflow flag. Slices chain through pcout -> pcin.
module dsp_mac_slice #(
  parameter int AW       = 18,
  parameter int BW       = 18,
  parameter int PW       = 48,
  parameter bit SATURATE = 1'b1,
  parameter int OPMODE_W = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ce,
  input  logic                    in_valid,
  input  logic signed [AW-1:0]    a,
  input  logic signed [BW-1:0]    b,
  input  logic signed [BW-1:0]    d,
  input  logic signed [PW-1:0]    c,
  input  logic signed [PW-1:0]    pcin,
  input  logic [OPMODE_W-1:0]     opmode,
  input  logic                    carryin,
  output logic                    out_valid,
  output logic signed [PW-1:0]    p,
  output logic signed [PW-1:0]    pcout,
  output logic signed [AW+BW:0]   m,
  output logic                    ovf
);

  localparam int MW = AW + BW + 1;
  localparam int SW = PW + 2;

  generate
    if (PW < MW) begin : g_pw_check
      $error("dsp_mac_slice: PW must be at least AW+BW+1");
    end
    if (OPMODE_W != 5) begin : g_op_check
      $error("dsp_mac_slice: OPMODE_W must be 5");
    end
  endgenerate

  function automatic logic signed [BW:0] pre_add(input logic [OPMODE_W-1:0] op,
                                                 input logic signed [BW-1:0] dv,
                                                 input logic signed [BW-1:0] bv);
    logic signed [BW:0] de;
    logic signed [BW:0] be;
    de = {dv[BW-1], dv};
    be = {bv[BW-1], bv};
    if (!op[0])     return be;
    else if (op[1]) return de - be;
    else            return de + be;
  endfunction

  // Sum is in range only when its top three bits agree.
  function automatic logic out_of_range(input logic signed [SW-1:0] s);
    return s[SW-1:PW-1] != {3{s[SW-1]}};
  endfunction

  function automatic logic signed [PW-1:0] clamp(input logic signed [SW-1:0] s);
    if (SATURATE && out_of_range(s))
      return s[SW-1] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
    return s[PW-1:0];
  endfunction

  logic signed [AW-1:0]  a_p1_q;
  logic signed [BW-1:0]  b_p1_q, d_p1_q;
  logic signed [PW-1:0]  c_p1_q, c_p2_q;
  logic [OPMODE_W-1:0]   op_p1_q, op_p2_q;
  logic                  ci_p1_q, ci_p2_q;
  logic                  vld_p1_q, vld_p2_q, vld_p3_q;
  logic signed [MW-1:0]  m_q, m_d;
  logic signed [PW-1:0]  p_q, p_d;
  logic                  ovf_q, ovf_d;

  logic signed [BW:0]    pre;
  logic signed [MW-1:0]  pre_x, a_x;
  logic signed [PW-1:0]  z_sel;
  logic signed [SW-1:0]  z_ext, x_ext, ci_ext, sum;
  logic                  sum_ovf;

  always_comb begin
    pre   = pre_add(op_p1_q, d_p1_q, b_p1_q);
    pre_x = {{AW{pre[BW]}}, pre};
    a_x   = {{(BW+1){a_p1_q[AW-1]}}, a_p1_q};
    m_d   = pre_x * a_x;
  end

  always_comb begin
    z_sel = '0;
    unique case (op_p2_q[3:2])
      2'b00: z_sel = '0;
      2'b01: z_sel = c_p2_q;
      2'b10: z_sel = p_q;
      2'b11: z_sel = pcin;
    endcase
    z_ext   = {{2{z_sel[PW-1]}}, z_sel};
    x_ext   = {{(SW-MW){m_q[MW-1]}}, m_q};
    ci_ext  = {{(SW-1){1'b0}}, ci_p2_q};
    sum     = op_p2_q[4] ? z_ext - (x_ext + ci_ext) : z_ext + x_ext + ci_ext;
    sum_ovf = out_of_range(sum);
    p_d     = p_q;
    ovf_d   = ovf_q;
    if (vld_p2_q) begin
      p_d   = clamp(sum);
      // A restart (Z=0) drops any earlier overflow history.
      ovf_d = (op_p2_q[3:2] == 2'b00) ? sum_ovf : (ovf_q | sum_ovf);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_p1_q   <= '0;
      b_p1_q   <= '0;
      d_p1_q   <= '0;
      c_p1_q   <= '0;
      op_p1_q  <= '0;
      ci_p1_q  <= 1'b0;
      vld_p1_q <= 1'b0;
      c_p2_q   <= '0;
      op_p2_q  <= '0;
      ci_p2_q  <= 1'b0;
      vld_p2_q <= 1'b0;
      m_q      <= '0;
      p_q      <= '0;
      ovf_q    <= 1'b0;
      vld_p3_q <= 1'b0;
    end else if (ce) begin
      // Stage 1: operand capture
      a_p1_q   <= a;
      b_p1_q   <= b;
      d_p1_q   <= d;
      c_p1_q   <= c;
      op_p1_q  <= opmode;
      ci_p1_q  <= carryin;
      vld_p1_q <= in_valid;
      // Stage 2: multiplier
      m_q      <= m_d;
      c_p2_q   <= c_p1_q;
      op_p2_q  <= op_p1_q;
      ci_p2_q  <= ci_p1_q;
      vld_p2_q <= vld_p1_q;
      // Stage 3: post-adder / accumulator
      p_q      <= p_d;
      ovf_q    <= ovf_d;
      vld_p3_q <= vld_p2_q;
    end
  end

  assign m         = m_q;
  assign p         = p_q;
  assign pcout     = p_q;
  assign ovf       = ovf_q;
  assign out_valid = vld_p3_q;

endmodule

// File: tb/tb_dsp_mac_slice.sv
// Bench for dsp_mac_slice: directed latency/arithmetic/accumulate/saturation steps on
// 48- and 40-bit slices, then a random two-slice cascade against a behavioural model.
module tb_dsp_mac_slice;

  localparam int N = 1000;

  logic clk, rst_n, ce;
  logic iv, ci, iv2, ci2;
  logic signed [17:0] a, b, d, a2, b2, d2;
  logic signed [47:0] c, c2, pcin0;
  logic [4:0] op, op2;

  logic signed [47:0] p1, pc1, p2, pc2;
  logic signed [36:0] m1, m2, ms, mw;
  logic signed [39:0] ps, pcs, pw, pcw;
  logic ov1, ovld1, ov2, ovld2, ovs, ovlds, ovw, ovldw;

  int checks = 0;
  int errors = 0;

  dsp_mac_slice #(.AW(18), .BW(18), .PW(48), .SATURATE(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(iv), .a(a), .b(b), .d(d), .c(c),
    .pcin(pcin0), .opmode(op), .carryin(ci), .out_valid(ovld1), .p(p1), .pcout(pc1),
    .m(m1), .ovf(ov1));

  dsp_mac_slice #(.AW(18), .BW(18), .PW(48), .SATURATE(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(iv2), .a(a2), .b(b2), .d(d2), .c(c2),
    .pcin(pc1), .opmode(op2), .carryin(ci2), .out_valid(ovld2), .p(p2), .pcout(pc2),
    .m(m2), .ovf(ov2));

  dsp_mac_slice #(.AW(18), .BW(18), .PW(40), .SATURATE(1'b1)) us (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(iv), .a(a), .b(b), .d(d), .c(c[39:0]),
    .pcin(pcin0[39:0]), .opmode(op), .carryin(ci), .out_valid(ovlds), .p(ps), .pcout(pcs),
    .m(ms), .ovf(ovs));

  dsp_mac_slice #(.AW(18), .BW(18), .PW(40), .SATURATE(1'b0)) uw (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(iv), .a(a), .b(b), .d(d), .c(c[39:0]),
    .pcin(pcin0[39:0]), .opmode(op), .carryin(ci), .out_valid(ovldw), .p(pw), .pcout(pcw),
    .m(mw), .ovf(ovw));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic signed [17:0] ta, input logic signed [17:0] tb_,
                        input logic signed [17:0] td, input logic signed [47:0] tc,
                        input logic [4:0] top, input logic tci, input logic tiv);
    a = ta; b = tb_; d = td; c = tc; op = top; ci = tci; iv = tiv;
  endtask

  // Reference: clamp or wrap an exact sum into a pw-bit signed register.
  function automatic longint fit(input longint s, input int pw, input bit sat,
                                 output bit o);
    longint lim, w;
    lim = longint'(1) <<< (pw - 1);
    o = (s >= lim) || (s < -lim);
    if (!o) return s;
    if (sat) return (s < 0) ? -lim : lim - 1;
    w = s & ((lim <<< 1) - 1);
    if (w >= lim) w = w - (lim <<< 1);
    return w;
  endfunction

  // Reference: one valid stage-3 result from the operand values.
  function automatic longint mac_ref(input logic [4:0] o, input longint av, input longint bv,
                                     input longint dv, input longint cv, input longint pv,
                                     input longint pcv, input bit civ);
    longint pre, x, z;
    pre = !o[0] ? bv : (o[1] ? dv - bv : dv + bv);
    x = pre * av;
    case (o[3:2])
      2'b00:   z = 0;
      2'b01:   z = cv;
      2'b10:   z = pv;
      default: z = pcv;
    endcase
    return o[4] ? z - (x + longint'(civ)) : z + x + longint'(civ);
  endfunction

  logic signed [17:0] ra[N], rb[N], rd[N], ra2[N], rb2[N], rd2[N];
  longint rc[N], e1[N], e2[N];
  logic [4:0] rop[N];
  bit rci[N], rv[N], eo1[N];

  initial begin : main
    int tv[10]  = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 0};
    int tce[10] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1};
    int tov[10] = '{0, 0, 1, 1, 0, 1, 1, 0, 1, 0};
    longint tp[10] = '{0, 0, 1000000, 1000000, 1000000, 2000000, 3000000, 3000000,
                       4000000, 4000000};
    longint es, ew, e48, p1m, p2m, big;
    bit os, ow, o, ovm;

    rst_n = 1'b0; ce = 1'b1; pcin0 = '0;
    set_op(18'sd0, 18'sd0, 18'sd0, 48'sd0, 5'b0, 1'b0, 1'b0);
    a2 = '0; b2 = '0; d2 = '0; c2 = '0; op2 = 5'b01100; ci2 = 1'b0; iv2 = 1'b0;
    #12 rst_n = 1'b1;
    tick();

    // Build up a nonzero state, then reset asynchronously mid-cycle.
    set_op(18'sd5, 18'sd5, 18'sd0, 48'sd0, 5'b00000, 1'b0, 1'b1);
    repeat (4) tick();
    chk("prestream_p", p1, 25);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_p", p1, 0);
    chk("rst_pcout", pc1, 0);
    chk("rst_m", m1, 0);
    chk("rst_ovf", ov1, 0);
    chk("rst_out_valid", ovld1, 0);
    chk("rst_p40", ps, 0);
    #3 rst_n = 1'b1;

    // Latency: one valid op, result three enabled cycles later.
    set_op(18'sd3, 18'sd4, 18'sd10, 48'sd0, 5'b00001, 1'b0, 1'b1);
    tick();
    iv = 1'b0;
    tick();
    chk("lat_m_2cyc", m1, 42);
    chk("lat_ovld_2cyc", ovld1, 0);
    tick();
    chk("lat_ovld", ovld1, 1);
    chk("lat_p", p1, 42);
    chk("lat_m", m1, 42);

    // Pre-subtract and post-subtract with carry-in.
    set_op(-18'sd7, 18'sd9, 18'sd5, 48'sd100, 5'b10111, 1'b1, 1'b1);
    tick();
    iv = 1'b0;
    repeat (2) tick();
    chk("presub_p", p1, 71);
    chk("presub_pcout", pc1, 71);

    // Restart to zero, then accumulate with bubbles and a frozen cycle.
    set_op(18'sd0, 18'sd0, 18'sd0, 48'sd0, 5'b00000, 1'b0, 1'b1);
    tick();
    iv = 1'b0;
    repeat (4) tick();
    chk("clr_p", p1, 0);
    set_op(18'sd1000, 18'sd1000, 18'sd0, 48'sd0, 5'b01000, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      iv = tv[i][0];
      ce = tce[i][0];
      tick();
      chk($sformatf("acc_p[%0d]", i), p1, tp[i]);
      chk($sformatf("acc_ovld[%0d]", i), ovld1, tov[i]);
    end
    ce = 1'b1;

    // Repeated accumulation of 2^34 until the 40-bit slices overflow.
    set_op(18'sd0, 18'sd0, 18'sd0, 48'sd0, 5'b00000, 1'b0, 1'b1);
    tick();
    iv = 1'b0;
    repeat (4) tick();
    set_op(18'(-131072), 18'(-131072), 18'sd0, 48'sd0, 5'b01000, 1'b0, 1'b0);
    es = 0; ew = 0; e48 = 0; os = 1'b0; ow = 1'b0;
    big = longint'(1) <<< 34;
    for (int i = 0; i < 36; i++) begin
      iv = (i < 34);
      tick();
      if (i >= 2) begin
        es  = fit(es + big, 40, 1'b1, o);  os = os | o;
        ew  = fit(ew + big, 40, 1'b0, o);  ow = ow | o;
        e48 = e48 + big;
        chk($sformatf("sat_p[%0d]", i - 2), ps, es);
        chk($sformatf("sat_ovf[%0d]", i - 2), ovs, os);
        chk($sformatf("wrap_p[%0d]", i - 2), pw, ew);
        chk($sformatf("wrap_ovf[%0d]", i - 2), ovw, ow);
        chk($sformatf("acc48_p[%0d]", i - 2), p1, e48);
      end
    end
    chk("sat_final_p", ps, (longint'(1) <<< 39) - 1);
    chk("wrap_negative", pw < 0, 1);

    // Restart clears the sticky flag.
    set_op(18'sd1, 18'sd1, 18'sd0, 48'sd0, 5'b00000, 1'b0, 1'b1);
    tick();
    iv = 1'b0;
    repeat (2) tick();
    chk("restart_sat_p", ps, 1);
    chk("restart_sat_ovf", ovs, 0);
    chk("restart_wrap_p", pw, 1);
    chk("restart_wrap_ovf", ovw, 0);
    repeat (2) tick();

    // Cascade: slice 2 is fed one cycle behind slice 1 so it adds slice 1's result.
    p1m = 1; p2m = 0; ovm = 1'b0;
    for (int i = 0; i < N; i++) begin
      ra[i]  = 18'($urandom);  rb[i]  = 18'($urandom);  rd[i] = 18'($urandom);
      ra2[i] = 18'($urandom);  rb2[i] = 18'($urandom);  rd2[i] = 18'($urandom);
      rc[i]  = longint'($signed($urandom)) <<< 8;
      rop[i] = 5'($urandom);
      rci[i] = 1'($urandom);
      rv[i]  = ($urandom_range(3, 0) != 0);
      if (rv[i]) begin
        p1m = fit(mac_ref(rop[i], longint'(ra[i]), longint'(rb[i]), longint'(rd[i]),
                          rc[i], p1m, 0, rci[i]), 48, 1'b1, o);
        ovm = (rop[i][3:2] == 2'b00) ? o : (ovm | o);
        p2m = fit(p1m + longint'(rb2[i]) * longint'(ra2[i]), 48, 1'b1, o);
      end
      e1[i] = p1m; eo1[i] = ovm; e2[i] = p2m;
    end
    for (int i = 0; i < N + 3; i++) begin
      if (i < N) begin
        set_op(ra[i], rb[i], rd[i], 48'(rc[i]), rop[i], rci[i], rv[i]);
      end else begin
        iv = 1'b0;
      end
      if (i >= 1 && i <= N) begin
        a2 = ra2[i-1]; b2 = rb2[i-1]; d2 = rd2[i-1]; iv2 = rv[i-1];
      end else begin
        iv2 = 1'b0;
      end
      tick();
      if (i >= 2 && i - 2 < N) begin
        chk($sformatf("casc1_p[%0d]", i - 2), p1, e1[i-2]);
        chk($sformatf("casc1_pcout[%0d]", i - 2), pc1, e1[i-2]);
        chk($sformatf("casc1_ovf[%0d]", i - 2), ov1, eo1[i-2]);
        chk($sformatf("casc1_ovld[%0d]", i - 2), ovld1, rv[i-2]);
      end
      if (i >= 3) begin
        chk($sformatf("casc2_p[%0d]", i - 3), p2, e2[i-3]);
        chk($sformatf("casc2_ovld[%0d]", i - 3), ovld2, rv[i-3]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_mac_slice.md
Name: dsp_mac_slice

Overview:
Parametrised pipelined multiply-accumulate slice for the DSP datapath. Pre-adder (D±B), signed multiplier (×A), and post-adder/accumulator with C, PCIN or P feedback. Adds features the fixed 18/48-bit slice lacks: generic operand widths, valid tracking, a global clock enable, saturating accumulation and a sticky overflow flag. Slices chain through PCOUT→PCIN.

Parameters:
AW, 18, signed width of A
BW, 18, signed width of B and D (pre-adder operands)
PW, 48, signed width of C, PCIN, P, PCOUT; must be ≥ AW+BW+1 (elaboration error otherwise)
SATURATE, 1, 1 = clamp P to signed PW range on overflow; 0 = two's-complement wrap
OPMODE_W, 5, opmode width (fixed at 5; present for chaining tools)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ce  in  1  global clock enable; 0 freezes all pipeline registers, including valids
in_valid  in  1  operands on a/b/d/c/opmode/carryin are valid this cycle
a  in  AW  signed multiplier operand
b  in  BW  signed pre-adder operand / direct multiplier operand
d  in  BW  signed pre-adder operand
c  in  PW  signed post-adder operand
pcin  in  PW  cascade input from previous slice
opmode  in  5  [0] pre-add enable, [1] pre-subtract, [3:2] Z select, [4] post-subtract
carryin  in  1  post-adder carry-in
out_valid  out  1  p/pcout/ovf hold the result of a valid input
p  out  PW  result register
pcout  out  PW  copy of p for cascade
m  out  AW+BW+1  multiplier register
ovf  out  1  sticky overflow flag

Behaviour:
- Reset (rst_n=0, async): all stage registers, m, p, pcout, ovf, out_valid = 0. Applies immediately, including mid-accumulation; first result after release starts from P=0.
- ce=0: no register changes; outputs held. ce=1: pipeline advances every cycle (no backpressure).
- Stage 1 (input regs): capture a,b,d,c,opmode,carryin,in_valid → v1. Regs capture regardless of in_valid; only v1 qualifies them.
- Stage 2 (M reg): pre = op[0] ? (op[1] ? d−b : d+b) : b, BW+1 bits signed, no overflow possible. m ← pre × a, AW+BW+1 bits signed, exact. v2 ← v1. Stage-1 c/opmode/carryin advance with it.
- Stage 3 (P reg), updated only when v2=1 (and ce=1); when v2=0, p/ovf hold.
  Z = 00:0, 01:c, 10:p (current register, accumulate), 11:pcin.
  X = m sign-extended to PW.
  sum = op[4] ? Z − (X + carryin) : Z + X + carryin, computed at PW+2 bits.
  If sum is outside the signed PW range: ovf ← 1; p ← SATURATE ? (sum<0 ? −2^(PW−1) : 2^(PW−1)−1) : sum[PW−1:0]. Otherwise p ← sum[PW−1:0].
- out_valid ← v2 each enabled cycle. Latency: in_valid → out_valid = 3 enabled cycles. Throughput 1/cycle.
- pcout = p combinationally (same register).
- Accumulate (Z=10) back-to-back: each valid stage-3 cycle uses p from the previous valid result. Invalid bubbles between valid accumulations do not alter p.
- ovf is sticky. It is cleared only by reset, or by a valid stage-3 op with Z=00 (accumulator restart), which sets ovf to that op's own overflow result.
- Saturated p is the new accumulator base; no hidden wider state.
- m updates on every enabled cycle and is observable with 2-cycle latency.

Test Plan:
- Reset/latency: rst_n low mid-stream → all outputs 0 asynchronously. Then a=3, b=4, d=10, op=00001 (Z=0, pre-add), one valid → 3 cycles later out_valid=1, p=42, m=42.
- Pre-subtract/post-subtract: d=5, b=9, a=−7, c=100, op=10111 (pre-sub, Z=c, post-sub), carryin=1 → p = 100−(28+1) = 71.
- Accumulate with bubbles: four valid a=1000, b=1000, op=01000 (Z=p, pre-add off), interleaved with in_valid=0 cycles and one ce=0 cycle → p=4,000,000 after the 4th out_valid, unchanged during bubbles.
- Saturation: PW=40, AW=BW=18; accumulate a=b=−2^17 (m=2^34) repeatedly → p clamps at 2^39−1, ovf=1 and stays 1. Next op with Z=00, a=b=1 → p=1, ovf=0.
- Wrap mode: same stimulus with SATURATE=0 → p wraps negative, ovf=1.
- Cascade: two instances, pcout→pcin; slice 2 op=01100 (Z=pcin) → slice 2 p = slice-1 p + own product, checked against a reference model over 1000 random vectors.
